bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Converts an unsigned binary word into packed BCD digits, one shift per clock.
- Produces the packed-BCD operand digits consumed by the BCD adder/subtractor datapath, for example from binary counters or switch inputs.
- Uses a start/busy/done handshake and holds its result until the next conversion completes.

Parameters:
- WIDTH, 8, width of the binary input in bits.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; the default converts 0..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned binary value; captured on the accepted start cycle.
- busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], and digit 0 is the units digit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, bcd_out=0.
  - Internal shift register and counter are cleared.
  - Reset mid-conversion aborts immediately; the partial result is discarded and bcd_out reads 0.
- Internal state:
  - Shift register {bcd_acc[4*DIGITS-1:0], bin_sh[WIDTH-1:0]}.
  - Bit counter cnt, ceil(log2(WIDTH+1)) bits wide.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE: busy=0, done=0. On start=1:
    - bin_sh<=bin_in, bcd_acc<=0, cnt<=0, next state SHIFT.
    - bin_in is not sampled again after this edge.
  - SHIFT: busy=1.
    - Each cycle, every digit of bcd_acc that is >=5 has 3 added to it, combinationally and in parallel.
    - The whole {bcd_acc,bin_sh} is then shifted left by 1; the MSB of bin_sh enters bit 0 of bcd_acc.
    - cnt increments each cycle. After the WIDTH-th shift (cnt==WIDTH-1 at the edge), next state is DONE.
  - DONE: busy=1, done=1 for exactly one cycle.
    - bcd_out<=final bcd_acc, registered at the edge entering DONE so it is valid when done=1.
    - Next state is IDLE unconditionally.
- Latency:
  - start sampled at edge N gives done=1 in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after start.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Boundary conditions:
  - start while busy=1, in SHIFT or DONE, is ignored. There is no queuing and no effect on the current result.
  - start held high continuously starts a new conversion on the first IDLE cycle after DONE.
  - bin_in changes during SHIFT have no effect.
  - bcd_out holds the previous result throughout a new conversion and updates only on entry to DONE.
  - All digits of bcd_out are always in 0..9. Input 0 yields all-zero digits. The maximum input 2^WIDTH-1 converts exactly with no overflow, guaranteed by the DIGITS constraint.
  - done is never asserted in the same cycle as busy=0.

Test Plan:
1. Reset, then bin_in=8'd255 with a one-cycle start pulse:
   - busy=1 for 9 cycles; done=1 in cycle 9 after start.
   - bcd_out=12'h255; busy=0 the following cycle.
2. Sequential conversions of 0, 99 and 100:
   - bcd_out=12'h000, 12'h099, 12'h100 respectively.
   - done pulses exactly once per conversion; bcd_out is unchanged between the done pulses.
3. Start 8'd55, then drive start=1 with bin_in=8'd200 at the 3rd SHIFT cycle:
   - Result is 12'h055.
   - No second conversion begins until the design returns to IDLE; a new start then converts 200 to 12'h200.
4. Start 8'd123, change bin_in to 8'd7 one cycle after start:
   - Result is 12'h123.
5. Start 8'd198, assert rst_n=0 asynchronously mid-SHIFT (between clock edges):
   - busy, done and bcd_out go to 0 immediately.
   - After release, start with 8'd66 gives 12'h066.
6. Hold start=1 permanently with bin_in=8'd42:
   - done pulses every 10 cycles and bcd_out=12'h042 each time.
   - Exhaustive sweep 0..255 checked against a reference model (hundreds, tens, units) with zero mismatches.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential binary-to-packed-BCD converter (shift-and-add-3),
//             one shift per clock, start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_bcd_w = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [c_bcd_w-1:0]   bcd_acc_q, bcd_acc_d;
    logic [WIDTH-1:0]     bin_sh_q,  bin_sh_d;
    logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
    logic [c_bcd_w-1:0]   bcd_out_q, bcd_out_d;

    // Accumulator after the add-3 correction, and after the following shift.
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_bcd_shifted;

    // Per-digit correction: any digit >= 5 gets +3 before the shift so that
    // doubling carries correctly into the next decimal digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        logic [3:0] w_dig;
        assign w_dig          = bcd_acc_q[4*g +: 4];
        assign w_adj[4*g +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    assign w_bcd_shifted = {w_adj[c_bcd_w-2:0], bin_sh_q[WIDTH-1]};

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_acc_q <= '0;
            bin_sh_q  <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_acc_q <= bcd_acc_d;
            bin_sh_q  <= bin_sh_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        bcd_acc_d = bcd_acc_q;
        bin_sh_d  = bin_sh_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_sh_d  = bin_in;
                    bcd_acc_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                bcd_acc_d = w_bcd_shifted;
                bin_sh_d  = {bin_sh_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == c_cnt_last) begin
                    // Result is published on entry to DONE so it is valid with done.
                    bcd_out_d = w_bcd_shifted;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bcd_out = bcd_out_q;

endmodule
`default_nettype wire
